avalon_burst_writer: RTL
========================

AVALON_BURST_WRITER -- requirements
Module: avalon_burst_writer

Interface
REQ-001 SHALL have parameter ADDRESS_WIDTH, default 32, byte-address width.
REQ-002 SHALL have parameter DATA_WIDTH, default 32, write data width (16..1024, power of 2).
REQ-003 SHALL have parameter LENGTH_WIDTH, default 16, transfer-length width in words.
REQ-004 SHALL have parameter BURST_MAX, default 8, max beats per burst (power of 2, 1..1024).
REQ-005 SHALL have parameter BURST_WIDTH, default 4, width of burstcount; must hold BURST_MAX.
REQ-006 SHALL have port clk, input, 1, clock.
REQ-007 SHALL have port reset, input, 1, asynchronous, active-high.
REQ-008 SHALL have port ctrl_start, input, 1, start request; sampled only in IDLE.
REQ-009 SHALL have port ctrl_baseaddress, input, ADDRESS_WIDTH, byte start address, word-aligned.
REQ-010 SHALL have port ctrl_length, input, LENGTH_WIDTH, total words to write.
REQ-011 SHALL have port ctrl_mode, input, 2, data mode: 0 constant, 1 increment, 2 toggle, 3 address-as-data.
REQ-012 SHALL have port ctrl_pattern, input, DATA_WIDTH, seed data word.
REQ-013 SHALL have port ctrl_busy, output, 1, high from accepted start until done.
REQ-014 SHALL have port ctrl_done, output, 1, single-cycle completion pulse.
REQ-015 SHALL have ports master_address (ADDRESS_WIDTH), master_write (1), master_writedata (DATA_WIDTH), master_burstcount (BURST_WIDTH), master_byteenable (DATA_WIDTH/8) as outputs, master_waitrequest (1) as input; Avalon-MM burst write master.

Function
REQ-016 SHALL implement states IDLE, BURST, DONE.
REQ-017 SHALL in IDLE, on ctrl_start=1, latch baseaddress, length, mode, pattern; go to BURST if length!=0, else DONE; ctrl_busy=1 from next cycle.
REQ-018 SHALL ignore ctrl_start outside IDLE; latched parameters stay stable for the whole transfer.
REQ-019 SHALL drive master_write=1 throughout BURST, including between back-to-back bursts (no idle cycle).
REQ-020 SHALL set master_burstcount = min(remaining words, BURST_MAX) at the first beat of each burst, held until its last beat is accepted.
REQ-021 SHALL hold master_address at the burst start address for all beats of a burst.
REQ-022 SHALL treat a beat as accepted when master_write=1 and master_waitrequest=0; on acceptance advance data, decrement remaining, increment beat counter.
REQ-023 SHALL hold address, data, burstcount unchanged while master_waitrequest=1.
REQ-024 SHALL, on last beat of a burst with remaining words >0, advance address by burstcount*(DATA_WIDTH/8) and start next burst the following cycle.
REQ-025 SHALL, on last beat of final burst, drop master_write next cycle and enter DONE.
REQ-026 SHALL in DONE assert ctrl_done for one cycle, clear ctrl_busy, return to IDLE; a new start is accepted the cycle after.
REQ-027 SHALL generate data per beat n (0-based, across whole transfer): mode 0 pattern; mode 1 pattern+n modulo 2^DATA_WIDTH; mode 2 pattern for even n, ~pattern for odd n; mode 3 byte address of beat's burst start plus n_in_burst*(DATA_WIDTH/8), zero-extended/truncated to DATA_WIDTH.
REQ-028 SHALL wrap address modulo 2^ADDRESS_WIDTH without error.
REQ-029 SHALL drive master_byteenable all ones at all times.
REQ-030 SHALL ignore master_waitrequest when master_write=0.

Reset
REQ-031 SHALL, on reset=1, immediately force IDLE, master_write=0, master_address=0, master_writedata=0, master_burstcount=0, ctrl_busy=0, ctrl_done=0, counters=0.
REQ-032 SHALL abandon any in-progress burst on reset without completing it and without asserting ctrl_done.

Verification
REQ-033 SHALL cover: base 0x38000000, length 8, BURST_MAX 8, mode 0, pattern 0x556699BB, no waitrequest -> one burst, burstcount 8, 8 beats of 0x556699BB at 0x38000000, done pulse once.
REQ-034 SHALL cover: length 20, mode 1, pattern 0 -> bursts 8,8,4 at 0x0,0x20,0x40, data 0..19 contiguous, write high continuously.
REQ-035 SHALL cover: waitrequest high on beats 0 and 5 for 3 cycles each -> outputs held stable, 8 beats total, data order unchanged.
REQ-036 SHALL cover: length 0 -> no write asserted, ctrl_busy high one cycle, ctrl_done one pulse.
REQ-037 SHALL cover: reset asserted mid-burst at beat 3 -> master_write 0 immediately, no done; new start after reset completes normally.
REQ-038 SHALL cover: ctrl_start pulsed while busy, and mode 2 with pattern 0xFFFF0000 -> second start ignored; data alternates 0xFFFF0000/0x0000FFFF.

Source files
------------

// File: rtl/avalon_burst_writer_if.sv
// Avalon-MM burst write bus between the pattern writer (master) and a memory
// or interconnect port (slave).
interface avalon_burst_writer_if #(
    parameter int ADDRESS_WIDTH = 32,
    parameter int DATA_WIDTH    = 32,
    parameter int BURST_WIDTH   = 4
);
    logic [ADDRESS_WIDTH-1:0]  address;
    logic                      write;
    logic [DATA_WIDTH-1:0]     writedata;
    logic [BURST_WIDTH-1:0]    burstcount;
    logic [DATA_WIDTH/8-1:0]   byteenable;
    logic                      waitrequest;

    modport master (
        output address,
        output write,
        output writedata,
        output burstcount,
        output byteenable,
        input  waitrequest
    );

    modport slave (
        input  address,
        input  write,
        input  writedata,
        input  burstcount,
        input  byteenable,
        output waitrequest
    );
endinterface

// File: rtl/avalon_burst_writer.sv
// Avalon-MM burst write master that fills a memory region with a generated
// data pattern. The transfer is split into bursts of at most BURST_MAX beats;
// write stays asserted across burst boundaries so bursts run back to back.
module avalon_burst_writer #(
    parameter int ADDRESS_WIDTH = 32,
    parameter int DATA_WIDTH    = 32,
    parameter int LENGTH_WIDTH  = 16,
    parameter int BURST_MAX     = 8,
    parameter int BURST_WIDTH   = 4
) (
    input  logic                      clk,
    input  logic                      reset,
    input  logic                      ctrl_start,
    input  logic [ADDRESS_WIDTH-1:0]  ctrl_baseaddress,
    input  logic [LENGTH_WIDTH-1:0]   ctrl_length,
    input  logic [1:0]                ctrl_mode,
    input  logic [DATA_WIDTH-1:0]     ctrl_pattern,
    output logic                      ctrl_busy,
    output logic                      ctrl_done,
    avalon_burst_writer_if.master     master
);

    localparam int BYTES      = DATA_WIDTH / 8;
    localparam int BYTE_SHIFT = $clog2(BYTES);
    // Wide enough to compare a length against BURST_MAX (up to 1024) without truncation.
    localparam int CMP_WIDTH  = (LENGTH_WIDTH > 11) ? LENGTH_WIDTH + 1 : 12;

    typedef enum logic [1:0] {
        S_IDLE,
        S_BURST,
        S_DONE
    } state_t;

    typedef enum logic [1:0] {
        MODE_CONST  = 2'd0,
        MODE_INCR   = 2'd1,
        MODE_TOGGLE = 2'd2,
        MODE_ADDR   = 2'd3
    } mode_t;

    state_t                    state, state_nxt;
    mode_t                     mode_q, mode_nxt;
    logic [DATA_WIDTH-1:0]     pattern_q, pattern_nxt;
    logic [ADDRESS_WIDTH-1:0]  burst_addr, burst_addr_nxt;   // start address of current burst
    logic [ADDRESS_WIDTH-1:0]  beat_addr, beat_addr_nxt;     // byte address of the presented beat
    logic [DATA_WIDTH-1:0]     data_q, data_nxt;
    logic [BURST_WIDTH-1:0]    burstcount_q, burstcount_nxt;
    logic [BURST_WIDTH-1:0]    beats_left, beats_left_nxt;   // beats still owed in this burst
    logic [LENGTH_WIDTH-1:0]   remaining, remaining_nxt;     // words still owed in the transfer
    logic [LENGTH_WIDTH-1:0]   beat_count, beat_count_nxt;   // beat index n across the transfer
    logic                      accept;

    // Size of the next burst: whatever is left, capped at BURST_MAX.
    function automatic logic [BURST_WIDTH-1:0] burst_len(input logic [LENGTH_WIDTH-1:0] words);
        if (CMP_WIDTH'(words) > CMP_WIDTH'(BURST_MAX)) begin
            return BURST_WIDTH'(BURST_MAX);
        end
        return BURST_WIDTH'(words);
    endfunction

    assign accept = (state == S_BURST) && !master.waitrequest;

    // State register.
    // NOTE: sequential state uses non-blocking assignments so every register
    // samples the pre-edge values, independent of block ordering.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state <= S_IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // Next-state and next-datapath values for the transfer sequencer.
    // NOTE: every variable gets its hold value first so no path through the
    // case leaves one unassigned, which would otherwise infer a latch.
    always_comb begin
        state_nxt      = state;
        mode_nxt       = mode_q;
        pattern_nxt    = pattern_q;
        burst_addr_nxt = burst_addr;
        beat_addr_nxt  = beat_addr;
        data_nxt       = data_q;
        burstcount_nxt = burstcount_q;
        beats_left_nxt = beats_left;
        remaining_nxt  = remaining;
        beat_count_nxt = beat_count;

        unique case (state)
            S_IDLE: begin
                if (ctrl_start) begin
                    mode_nxt       = mode_t'(ctrl_mode);
                    pattern_nxt    = ctrl_pattern;
                    burst_addr_nxt = ctrl_baseaddress;
                    beat_addr_nxt  = ctrl_baseaddress;
                    remaining_nxt  = ctrl_length;
                    beat_count_nxt = '0;
                    burstcount_nxt = burst_len(ctrl_length);
                    beats_left_nxt = burst_len(ctrl_length);
                    // Beat 0 is the seed in every mode except address-as-data.
                    data_nxt       = (mode_t'(ctrl_mode) == MODE_ADDR) ?
                                     DATA_WIDTH'(ctrl_baseaddress) : ctrl_pattern;
                    state_nxt      = (ctrl_length != '0) ? S_BURST : S_DONE;
                end
            end

            S_BURST: begin
                if (accept) begin
                    remaining_nxt  = remaining - LENGTH_WIDTH'(1);
                    beat_count_nxt = beat_count + LENGTH_WIDTH'(1);
                    beats_left_nxt = beats_left - BURST_WIDTH'(1);

                    if (beats_left == BURST_WIDTH'(1)) begin
                        if (remaining == LENGTH_WIDTH'(1)) begin
                            state_nxt = S_DONE;
                        end else begin
                            // Next burst starts right after the one just finished;
                            // the address wraps naturally at ADDRESS_WIDTH bits.
                            burst_addr_nxt = burst_addr + (ADDRESS_WIDTH'(burstcount_q) << BYTE_SHIFT);
                            beat_addr_nxt  = burst_addr_nxt;
                            burstcount_nxt = burst_len(remaining_nxt);
                            beats_left_nxt = burstcount_nxt;
                        end
                    end else begin
                        beat_addr_nxt = beat_addr + ADDRESS_WIDTH'(BYTES);
                    end

                    unique case (mode_q)
                        MODE_CONST:  data_nxt = pattern_q;
                        MODE_INCR:   data_nxt = pattern_q + DATA_WIDTH'(beat_count_nxt);
                        MODE_TOGGLE: data_nxt = beat_count_nxt[0] ? ~pattern_q : pattern_q;
                        MODE_ADDR:   data_nxt = DATA_WIDTH'(beat_addr_nxt);
                    endcase
                end
            end

            S_DONE: begin
                state_nxt = S_IDLE;
            end

            default: begin
                state_nxt = S_IDLE;
            end
        endcase
    end

    // Datapath registers: latched parameters, bus outputs and counters.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            mode_q       <= MODE_CONST;
            pattern_q    <= '0;
            burst_addr   <= '0;
            beat_addr    <= '0;
            data_q       <= '0;
            burstcount_q <= '0;
            beats_left   <= '0;
            remaining    <= '0;
            beat_count   <= '0;
        end else begin
            mode_q       <= mode_nxt;
            pattern_q    <= pattern_nxt;
            burst_addr   <= burst_addr_nxt;
            beat_addr    <= beat_addr_nxt;
            data_q       <= data_nxt;
            burstcount_q <= burstcount_nxt;
            beats_left   <= beats_left_nxt;
            remaining    <= remaining_nxt;
            beat_count   <= beat_count_nxt;
        end
    end

    // Outputs decode straight from registers, so reset clears them at once.
    assign ctrl_busy         = (state != S_IDLE);
    assign ctrl_done         = (state == S_DONE);
    assign master.write      = (state == S_BURST);
    assign master.address    = burst_addr;
    assign master.writedata  = data_q;
    assign master.burstcount = burstcount_q;
    assign master.byteenable = '1;

endmodule
